alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Initiator-side sequencer that drives the 8-bit combinational ALU port: alu_cmd, two operands and the shift/carry-in bit.
- Captures the ALU result and the `one` branch flag on the clock edge.
- Builds 16-bit (two-byte) add/sub/logic/eq operations out of one to three ALU passes, so multi-byte arithmetic in the processor datapath does not need a wider ALU.
- Sits between the control unit (request side) and the ALU (responder side).

Parameters:
- DW, 8, ALU operand width; the wide word is 2*DW bits.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request (high only in IDLE)
- req_op  input  4  ALU opcode, same encoding as alu_cmd
- req_wide  input  1  1 = 16-bit operation, 0 = 8-bit operation on the low bytes
- req_a  input  2*DW  operand A
- req_b  input  2*DW  operand B
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes the result
- rsp_rslt  output  2*DW  result
- rsp_flag  output  1  carry/borrow for add/sub; equality/less-than for eq/lt; 0 otherwise
- rsp_err  output  1  wide request used an opcode with no wide support
- alu_cmd  output  4  to ALU
- alu_inA  output  DW  to ALU
- alu_inB  output  DW  to ALU
- alu_sc_i  output  1  to ALU; constant 0
- alu_rslt  input  DW  from ALU
- alu_one  input  1  from ALU; sampled only for eq (1101) and lt (1110)

Behaviour:
- Interface: one clock, clk. Asynchronous active-high reset, reset.
- Reset values:
  - State IDLE.
  - req_ready=1, rsp_valid=0, rsp_rslt=0, rsp_flag=0, rsp_err=0.
  - Internal operand, carry and partial-result registers cleared.
- Reset mid-operation aborts immediately; no response is produced.
- States: IDLE, LO, HI, FIX, DONE.
- IDLE:
  - req_valid&req_ready latches op/wide/a/b and moves to LO.
  - alu_cmd=0000, alu_inA=0, alu_inB=0.
- LO:
  - Drives alu_cmd=op, alu_inA=a[DW-1:0], alu_inB=b[DW-1:0].
  - Captures alu_rslt into rslt_lo and alu_one into one_lo.
  - Captures carry: add: lo_sum < a_lo; sub: a_lo < b_lo.
  - Next state: HI if wide and op is supported wide, else DONE.
- HI:
  - Drives op on the high bytes; captures into rslt_hi and one_hi.
  - Next state: FIX if op is add/sub and the captured carry/borrow = 1, else DONE.
- FIX:
  - add: alu_cmd=0000, inA=rslt_hi, inB=1.
  - sub: alu_cmd=0001, inA=rslt_hi, inB=1.
  - Result overwrites rslt_hi. Next state: DONE.
- DONE:
  - rsp_valid=1; outputs stable until rsp_ready.
  - On rsp_ready: go to IDLE, rsp_valid drops the next cycle.
  - No new request is accepted in the same cycle as the response handshake; back-to-back throughput is one request per (latency+1) cycles.
- Latency from accept to rsp_valid:
  - narrow 2 cycles;
  - wide without fix 3 cycles;
  - wide with fix 4 cycles.
- Wide-supported ops: add 0000, sub 0001, nor 0111, xor 1000, and 1001, or 1010, eq 1101.
- Wide request with any other op:
  - executes narrow on the low bytes, rsp_rslt[2*DW-1:DW]=0, rsp_err=1.
  - Exception: lt 1110 when ALU_SEQ_WIDE_LT_EN is defined (see Optional Feature).
- Narrow result: {0, rslt_lo}; rsp_err=0.
- rsp_flag:
  - add: bit 16 of the 17-bit sum of a and b (narrow: bit 8 of the low-byte sum);
  - sub: unsigned a<b over the operated width;
  - eq: one_lo & one_hi (narrow: one_lo);
  - lt: narrow one_lo; wide per Optional Feature;
  - all other ops: 0.
  - The flag is computed from latched operands and ALU results; alu_one is never sampled for non-compare ops, since it is X there.
- Wrap-around is modulo 2^16 for wide and 2^8 for narrow:
  - add FFFF+0001 gives 0000, flag 1.
  - FIX on rslt_hi=FF gives 00 with no further step.
- alu_sc_i is always 0.
- rsp_ready asserted while not in DONE is ignored.
- req_valid outside IDLE is ignored; the requester must hold it.

Optional Feature:
- Macro: ALU_SEQ_WIDE_LT_EN.
- Defined:
  - Wide lt is supported using states HI_LT, HI_EQ, LO_LT.
  - HI_LT: alu lt on the high bytes; if one=1, DONE with flag 1.
  - HI_EQ: alu eq on the high bytes; if one=0, DONE with flag 0.
  - LO_LT: alu lt on the low bytes; flag = alu_one.
  - rsp_rslt = {0, flag}; rsp_err=0.
- Undefined: wide lt is treated as unsupported (narrow on low bytes, rsp_err=1).

Test Plan:
- Reset asserted mid-LO of wide add 1234+00FF → rsp_valid=0 and req_ready=1 immediately, no response after release; then narrow add a=0x0005 b=0x0003 → rsp_valid 2 cycles after accept, rslt=0x0008, flag 0.
- Wide add 0x12FF+0x0001 → FIX taken, rsp at cycle 4, rslt=0x1300, flag 0; wide add 0xFFFF+0x0001 → rslt=0x0000, flag 1.
- Wide sub 0x1000-0x0001 → borrow FIX, rslt=0x0FFF, flag 0; wide sub 0x0001-0x0002 → rslt=0xFFFF, flag 1.
- Wide eq 0xABCD vs 0xABCE → flag 0, 3-cycle latency; vs 0xABCD → flag 1.
- Wide lt 0x0100 vs 0x00FF → without macro: rsp_err=1, flag from low bytes (00<FF)=1; with macro: flag 0, rsp_err 0.
- Backpressure: hold rsp_ready=0 for 5 cycles with wide xor 0xF0F0^0xFFFF → rsp_rslt=0x0F0F stable, req_ready=0 throughout; release → IDLE next cycle.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Initiator-side sequencer for an 8-bit combinational ALU.
//                Builds 2*DW-bit add/sub/logic/eq operations out of one to
//                three ALU passes (low bytes, high bytes, optional carry or
//                borrow fix-up on the high byte). Narrow requests use one
//                pass on the low bytes.
//  Optional    : `define ALU_SEQ_WIDE_LT_EN adds wide unsigned less-than
//                (high-lt, high-eq, low-lt passes).
//  Ports       : clk, reset           - clock, async active-high reset
//                req_valid/req_ready  - request handshake (ready only in IDLE)
//                req_op/req_wide      - opcode (ALU encoding), 16/8-bit select
//                req_a/req_b          - operands, 2*DW bits
//                rsp_valid/rsp_ready  - response handshake
//                rsp_rslt/rsp_flag    - result and carry/borrow/compare flag
//                rsp_err              - wide request with unsupported opcode
//                alu_cmd/alu_inA/alu_inB/alu_sc_i - drive to ALU
//                alu_rslt/alu_one     - result and branch flag from ALU
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic            req_wide,
    input  logic [2*DW-1:0] req_a,
    input  logic [2*DW-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2*DW-1:0] rsp_rslt,
    output logic            rsp_flag,
    output logic            rsp_err,
    output logic [3:0]      alu_cmd,
    output logic [DW-1:0]   alu_inA,
    output logic [DW-1:0]   alu_inB,
    output logic            alu_sc_i,
    input  logic [DW-1:0]   alu_rslt,
    input  logic            alu_one
);

    // ALU opcodes
    localparam logic [3:0] c_op_add = 4'b0000;
    localparam logic [3:0] c_op_sub = 4'b0001;
    localparam logic [3:0] c_op_nor = 4'b0111;
    localparam logic [3:0] c_op_xor = 4'b1000;
    localparam logic [3:0] c_op_and = 4'b1001;
    localparam logic [3:0] c_op_or  = 4'b1010;
    localparam logic [3:0] c_op_eq  = 4'b1101;
    localparam logic [3:0] c_op_lt  = 4'b1110;

    // Sequencer states
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_lo    = 3'd1;
    localparam logic [2:0] c_st_hi    = 3'd2;
    localparam logic [2:0] c_st_fix   = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;
`ifdef ALU_SEQ_WIDE_LT_EN
    localparam logic [2:0] c_st_hi_lt = 3'd5;
    localparam logic [2:0] c_st_hi_eq = 3'd6;
    localparam logic [2:0] c_st_lo_lt = 3'd7;
`endif

    localparam logic [DW-1:0] c_one = {{(DW-1){1'b0}}, 1'b1};

    logic [2:0]      r_state;
    logic [3:0]      r_op;
    logic            r_wide;     // wide request with a wide-capable opcode
    logic            r_err;
    logic [2*DW-1:0] r_a;
    logic [2*DW-1:0] r_b;
    logic            r_carry;    // low-byte carry (add) or borrow (sub)
    logic [DW-1:0]   r_rslt_lo;
    logic [DW-1:0]   r_rslt_hi;
    logic            r_one_lo;
    logic            r_one_hi;

    logic [DW-1:0]   w_a_lo;
    logic [DW-1:0]   w_a_hi;
    logic [DW-1:0]   w_b_lo;
    logic [DW-1:0]   w_b_hi;
    logic            w_cmp_op;
    logic            w_arith_op;

    function automatic logic wide_supported(input logic [3:0] op);
        case (op)
            c_op_add, c_op_sub, c_op_nor, c_op_xor,
            c_op_and, c_op_or, c_op_eq: wide_supported = 1'b1;
`ifdef ALU_SEQ_WIDE_LT_EN
            c_op_lt:                    wide_supported = 1'b1;
`endif
            default:                    wide_supported = 1'b0;
        endcase
    endfunction

    assign w_a_lo     = r_a[DW-1:0];
    assign w_a_hi     = r_a[2*DW-1:DW];
    assign w_b_lo     = r_b[DW-1:0];
    assign w_b_hi     = r_b[2*DW-1:DW];
    // alu_one is only meaningful for compare opcodes; it is masked otherwise
    assign w_cmp_op   = (r_op == c_op_eq) || (r_op == c_op_lt);
    assign w_arith_op = (r_op == c_op_add) || (r_op == c_op_sub);

    assign req_ready = (r_state == c_st_idle);
    assign rsp_valid = (r_state == c_st_done);
    assign rsp_rslt  = {r_rslt_hi, r_rslt_lo};
    assign rsp_err   = r_err;
    assign alu_sc_i  = 1'b0;

    // Flag derived from latched operands and captured results only, so it
    // stays stable for the whole DONE phase.
    always_comb begin
        rsp_flag = 1'b0;
        case (r_op)
            // a modular sum smaller than an addend means a carry out
            c_op_add: rsp_flag = r_wide ? ({r_rslt_hi, r_rslt_lo} < r_a)
                                        : (r_rslt_lo < w_a_lo);
            c_op_sub: rsp_flag = r_wide ? (r_a < r_b) : (w_a_lo < w_b_lo);
            c_op_eq:  rsp_flag = r_wide ? (r_one_lo & r_one_hi) : r_one_lo;
            c_op_lt:  rsp_flag = r_one_lo;
            default:  rsp_flag = 1'b0;
        endcase
    end

    // ALU drive
    always_comb begin
        alu_cmd = c_op_add;
        alu_inA = '0;
        alu_inB = '0;
        case (r_state)
            c_st_lo: begin
                alu_cmd = r_op;
                alu_inA = w_a_lo;
                alu_inB = w_b_lo;
            end
            c_st_hi: begin
                alu_cmd = r_op;
                alu_inA = w_a_hi;
                alu_inB = w_b_hi;
            end
            c_st_fix: begin
                // propagate the low-byte carry (+1) or borrow (-1)
                alu_cmd = (r_op == c_op_sub) ? c_op_sub : c_op_add;
                alu_inA = r_rslt_hi;
                alu_inB = c_one;
            end
`ifdef ALU_SEQ_WIDE_LT_EN
            c_st_hi_lt: begin
                alu_cmd = c_op_lt;
                alu_inA = w_a_hi;
                alu_inB = w_b_hi;
            end
            c_st_hi_eq: begin
                alu_cmd = c_op_eq;
                alu_inA = w_a_hi;
                alu_inB = w_b_hi;
            end
            c_st_lo_lt: begin
                alu_cmd = c_op_lt;
                alu_inA = w_a_lo;
                alu_inB = w_b_lo;
            end
`endif
            default: begin
                alu_cmd = c_op_add;
                alu_inA = '0;
                alu_inB = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_op      <= 4'b0000;
            r_wide    <= 1'b0;
            r_err     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_carry   <= 1'b0;
            r_rslt_lo <= '0;
            r_rslt_hi <= '0;
            r_one_lo  <= 1'b0;
            r_one_hi  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_op      <= req_op;
                        r_a       <= req_a;
                        r_b       <= req_b;
                        r_wide    <= req_wide & wide_supported(req_op);
                        r_err     <= req_wide & ~wide_supported(req_op);
                        r_carry   <= 1'b0;
                        // high half stays zero for narrow/unsupported requests
                        r_rslt_hi <= '0;
                        r_one_hi  <= 1'b0;
                        r_state   <= c_st_lo;
                    end
                end
                c_st_lo: begin
                    r_rslt_lo <= alu_rslt;
                    r_one_lo  <= w_cmp_op & alu_one;
                    if (r_op == c_op_add) begin
                        r_carry <= (alu_rslt < w_a_lo);
                    end else if (r_op == c_op_sub) begin
                        r_carry <= (w_a_lo < w_b_lo);
                    end else begin
                        r_carry <= 1'b0;
                    end
                    if (!r_wide) begin
                        r_state <= c_st_done;
`ifdef ALU_SEQ_WIDE_LT_EN
                    end else if (r_op == c_op_lt) begin
                        r_state <= c_st_hi_lt;
`endif
                    end else begin
                        r_state <= c_st_hi;
                    end
                end
                c_st_hi: begin
                    r_rslt_hi <= alu_rslt;
                    r_one_hi  <= w_cmp_op & alu_one;
                    r_state   <= (w_arith_op && r_carry) ? c_st_fix : c_st_done;
                end
                c_st_fix: begin
                    r_rslt_hi <= alu_rslt;
                    r_state   <= c_st_done;
                end
                c_st_done: begin
                    if (rsp_ready) begin
                        r_state <= c_st_idle;
                    end
                end
`ifdef ALU_SEQ_WIDE_LT_EN
                // Final lt flag is kept in r_one_lo and mirrored in bit 0
                // of the result.
                c_st_hi_lt: begin
                    if (alu_one) begin
                        r_one_lo  <= 1'b1;
                        r_rslt_lo <= c_one;
                        r_state   <= c_st_done;
                    end else begin
                        r_state   <= c_st_hi_eq;
                    end
                end
                c_st_hi_eq: begin
                    if (!alu_one) begin
                        r_one_lo  <= 1'b0;
                        r_rslt_lo <= '0;
                        r_state   <= c_st_done;
                    end else begin
                        r_state   <= c_st_lo_lt;
                    end
                end
                c_st_lo_lt: begin
                    r_one_lo  <= alu_one;
                    r_rslt_lo <= {{(DW-1){1'b0}}, alu_one};
                    r_state   <= c_st_done;
                end
`endif
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq. Provides a behavioural
//                8-bit ALU responder, directed scenarios and randomized
//                requests checked against a 16-bit arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_op;
    logic            req_wide;
    logic [2*DW-1:0] req_a;
    logic [2*DW-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [2*DW-1:0] rsp_rslt;
    logic            rsp_flag;
    logic            rsp_err;
    logic [3:0]      alu_cmd;
    logic [DW-1:0]   alu_inA;
    logic [DW-1:0]   alu_inB;
    logic            alu_sc_i;
    logic [DW-1:0]   alu_rslt;
    logic            alu_one;
    logic            noise;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural ALU responder
    function automatic logic [7:0] alu_f(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
        case (c)
            4'h0:       alu_f = x + y;
            4'h1:       alu_f = x - y;
            4'h2:       alu_f = x << 1;
            4'h3:       alu_f = x >> 1;
            4'h7:       alu_f = ~(x | y);
            4'h8:       alu_f = x ^ y;
            4'h9:       alu_f = x & y;
            4'hA:       alu_f = x | y;
            4'hD, 4'hE: alu_f = 8'h00;
            default:    alu_f = x ^ {y[3:0], c};
        endcase
    endfunction

    // alu_one carries junk for non-compare commands
    always @(negedge clk) noise <= 1'($urandom_range(0, 1));

    assign alu_rslt = alu_f(alu_cmd, alu_inA, alu_inB);
    assign alu_one  = (alu_cmd == 4'hD) ? (alu_inA == alu_inB) :
                      (alu_cmd == 4'hE) ? (alu_inA <  alu_inB) : noise;

    alu_seq #(.DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_wide  (req_wide),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rslt  (rsp_rslt),
        .rsp_flag  (rsp_flag),
        .rsp_err   (rsp_err),
        .alu_cmd   (alu_cmd),
        .alu_inA   (alu_inA),
        .alu_inB   (alu_inB),
        .alu_sc_i  (alu_sc_i),
        .alu_rslt  (alu_rslt),
        .alu_one   (alu_one)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the sequenced operation viewed as plain 16/8-bit maths
    task automatic model(input logic [3:0] op, input logic w, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic f, output logic e, output int lat);
        logic        ws;
        logic [16:0] s;
        ws = w && (op == 4'h0 || op == 4'h1 || op == 4'h7 || op == 4'h8 ||
                   op == 4'h9 || op == 4'hA || op == 4'hD);
`ifdef ALU_SEQ_WIDE_LT_EN
        if (w && op == 4'hE) ws = 1'b1;
`endif
        e   = w && !ws;
        f   = 1'b0;
        r   = 16'h0000;
        lat = 3;
        if (!ws) begin
            r   = {8'h00, alu_f(op, a[7:0], b[7:0])};
            lat = 2;
            case (op)
                4'h0: f = (int'(a[7:0]) + int'(b[7:0])) > 255;
                4'h1: f = a[7:0] < b[7:0];
                4'hD: f = a[7:0] == b[7:0];
                4'hE: f = a[7:0] < b[7:0];
                default: f = 1'b0;
            endcase
        end else begin
            case (op)
                4'h0: begin
                    s = {1'b0, a} + {1'b0, b};
                    r = s[15:0];
                    f = s[16];
                    if ((int'(a[7:0]) + int'(b[7:0])) > 255) lat = 4;
                end
                4'h1: begin
                    r = a - b;
                    f = a < b;
                    if (a[7:0] < b[7:0]) lat = 4;
                end
                4'h7: r = ~(a | b);
                4'h8: r = a ^ b;
                4'h9: r = a & b;
                4'hA: r = a | b;
                4'hD: f = (a == b);
                default: begin
                    f   = a < b;
                    r   = {15'h0000, f};
                    lat = (a[15:8] < b[15:8]) ? 3 : (a[15:8] != b[15:8]) ? 4 : 5;
                end
            endcase
        end
    endtask

    // One full request/response transaction with expectations supplied
    task automatic do_op(input string tag, input logic [3:0] op, input logic w,
                         input logic [15:0] a, input logic [15:0] b,
                         input int exp_lat, input logic [15:0] exp_r, input logic exp_f,
                         input logic exp_e, input int hold, input logic noisy);
        int n;
        logic [15:0] held;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " req_ready_before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_wide  = w;
        req_a     = a;
        req_b     = b;
        rsp_ready = noisy;
        tick();
        // while busy, inputs may wiggle freely and must be ignored
        req_valid = noisy;
        req_op    = 4'($urandom);
        req_wide  = 1'($urandom);
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
        n = 1;
        while (!rsp_valid && n < 12) begin
            chk({tag, " alu_sc_i"}, 32'(alu_sc_i), 32'd0);
            tick();
            n++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " rslt"}, 32'(rsp_rslt), 32'(exp_r));
        chk({tag, " flag"}, 32'(rsp_flag), 32'(exp_f));
        chk({tag, " err"}, 32'(rsp_err), 32'(exp_e));
        chk({tag, " req_ready_busy"}, 32'(req_ready), 32'd0);
        held = rsp_rslt;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, " hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " hold_rslt"}, 32'(rsp_rslt), 32'(held));
            chk({tag, " hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, " valid_after"}, 32'(rsp_valid), 32'd0);
        chk({tag, " ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [3:0]  op;
        logic        w;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] er;
        logic        ef;
        logic        ee;
        int          el;
        int          seen;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'h0;
        req_wide  = 1'b0;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rslt", 32'(rsp_rslt), 32'd0);
        chk("reset rsp_flag", 32'(rsp_flag), 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        tick();

        // Abort a wide add while it is in its low-byte pass
        req_valid = 1'b1;
        req_op    = 4'h0;
        req_wide  = 1'b1;
        req_a     = 16'h1234;
        req_b     = 16'h00FF;
        tick();
        req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort req_ready", 32'(req_ready), 32'd1);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        chk("abort no_response", 32'(seen), 32'd0);

        do_op("narrow_add", 4'h0, 1'b0, 16'h0005, 16'h0003, 2, 16'h0008, 1'b0, 1'b0, 0, 1'b0);
        do_op("add_fix", 4'h0, 1'b1, 16'h12FF, 16'h0001, 4, 16'h1300, 1'b0, 1'b0, 0, 1'b0);
        do_op("add_wrap", 4'h0, 1'b1, 16'hFFFF, 16'h0001, 4, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        do_op("sub_fix", 4'h1, 1'b1, 16'h1000, 16'h0001, 4, 16'h0FFF, 1'b0, 1'b0, 0, 1'b0);
        do_op("sub_wrap", 4'h1, 1'b1, 16'h0001, 16'h0002, 4, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
        do_op("eq_ne", 4'hD, 1'b1, 16'hABCD, 16'hABCE, 3, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        do_op("eq_eq", 4'hD, 1'b1, 16'hABCD, 16'hABCD, 3, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
`ifdef ALU_SEQ_WIDE_LT_EN
        do_op("wide_lt", 4'hE, 1'b1, 16'h0100, 16'h00FF, 4, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
`else
        do_op("wide_lt", 4'hE, 1'b1, 16'h0100, 16'h00FF, 2, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
`endif
        do_op("wide_shl", 4'h2, 1'b1, 16'h12C3, 16'h5555, 2, 16'h0086, 1'b0, 1'b1, 0, 1'b0);
        do_op("xor_bp", 4'h8, 1'b1, 16'hF0F0, 16'hFFFF, 3, 16'h0F0F, 1'b0, 1'b0, 5, 1'b0);

        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 15));
            w  = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
            if ($urandom_range(0, 3) == 0) b[15:8] = a[15:8];
            model(op, w, a, b, er, ef, ee, el);
            do_op("rand", op, w, a, b, el, er, ef, ee,
                  int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
